iddmm_arb: RTL and testbench

IDDMM_ARB -- requirements
Module: iddmm_arb

---
 rtl/iddmm_pkg.sv | 17 +
 rtl/iddmm_rr_pick.sv | 38 +++
 rtl/iddmm_arb.sv | 156 +++++++++++++++
 tb/tb_iddmm_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
// Shared types and default parameters for the IDDMM engine arbiter.
// Holds the arbiter state encoding used by iddmm_arb.
package iddmm_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BUSY  = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_t;

    localparam int IDDMM_K_DEF       = 256;
    localparam int IDDMM_N_DEF       = 16;
    localparam int IDDMM_R_DEF       = 4;
    localparam int IDDMM_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/iddmm_rr_pick.sv
// Combinational round-robin picker: returns the one-hot winner among req,
// searching upward from the requester after last_owner.
import iddmm_pkg::*;

module iddmm_rr_pick #(
    parameter int R  = IDDMM_R_DEF,
    parameter int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [R-1:0]  winner
);

    logic [IW:0] idx_s;
    logic        found_s;

    // First requesting index after last_owner, wrapping modulo R
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= R; i++) begin
            idx_s = {1'b0, last_owner} + i[IW:0];
            if (idx_s >= (IW+1)'(R)) begin
                idx_s = idx_s - (IW+1)'(R);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[IW-1:0]]) begin
                winner[idx_s[IW-1:0]] = 1'b1;
                found_s               = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/iddmm_arb.sv
// Round-robin arbiter sharing one IDDMM engine among R requesters.
// Optional watchdog abort is enabled by defining IDDMM_ARB_TIMEOUT_EN.
import iddmm_pkg::*;

module iddmm_arb #(
    parameter int K       = IDDMM_K_DEF,
    parameter int N       = IDDMM_N_DEF,
    parameter int R       = IDDMM_R_DEF,
    parameter int TIMEOUT = IDDMM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         req,
    output logic [R-1:0]         gnt,
    output logic [$clog2(R)-1:0] owner_id,
    output logic [K-1:0]         res_data,
    output logic [R-1:0]         res_valid,
    output logic [R-1:0]         done,
    output logic [R-1:0]         err,
    output logic                 eng_task_req,
    input  logic                 eng_task_grant,
    input  logic                 eng_task_end,
    input  logic [K-1:0]         eng_task_res
);

    localparam int IW = $clog2(R);

    if (R < 2 || N < 1 || TIMEOUT < 2) begin : g_param_chk
        $error("iddmm_arb: illegal parameter set");
    end

    arb_state_t    state_r, state_s;
    logic [R-1:0]  gnt_r, gnt_s;
    logic [IW-1:0] owner_id_r, owner_id_s;
    logic [IW-1:0] last_owner_r, last_owner_s;
    logic          eng_req_r;
    logic [R-1:0]  win_s;
    logic [IW-1:0] win_idx_s;
    logic [R-1:0]  res_valid_s, done_s, err_s;
    logic          timeout_hit_s;

    iddmm_rr_pick #(.R(R), .IW(IW)) u_pick (
        .req        (req),
        .last_owner (last_owner_r),
        .winner     (win_s)
    );

    // One-hot winner to binary index for the operand-select mux
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < R; i++) begin
            if (win_s[i]) begin
                win_idx_s = IW'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

`ifdef IDDMM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wdog_r;

    // Watchdog: cleared when a job is issued, counts engine busy cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if (state_r == ARB_ISSUE) begin
            wdog_r <= '0;
        end else if (state_r == ARB_BUSY) begin
            wdog_r <= wdog_r + CW'(1);
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign timeout_hit_s = (wdog_r == CW'(TIMEOUT - 1));
    assign err           = err_s;
`else
    assign timeout_hit_s = 1'b0;
    assign err           = '0;
`endif

    // Next-state and per-cycle strobes; word/done qualification only in BUSY
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        owner_id_s   = owner_id_r;
        last_owner_s = last_owner_r;
        res_valid_s  = '0;
        done_s       = '0;
        err_s        = '0;
        case (state_r)
            ARB_IDLE: begin
                if (|req) begin
                    gnt_s      = win_s;
                    owner_id_s = win_idx_s;
                    state_s    = ARB_ISSUE;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                state_s = ARB_BUSY;
            end
            ARB_BUSY: begin
                res_valid_s = gnt_r & {R{eng_task_grant}};
                if (eng_task_end) begin
                    done_s       = gnt_r;
                    gnt_s        = '0;
                    last_owner_s = owner_id_r;
                    state_s      = ARB_GAP;
                end else if (timeout_hit_s) begin
                    err_s        = gnt_r;
                    gnt_s        = '0;
                    last_owner_s = owner_id_r;
                    state_s      = ARB_GAP;
                end else begin
                    state_s = ARB_BUSY;
                end
            end
            ARB_GAP: begin
                state_s = ARB_IDLE;
            end
            default: begin
                state_s = ARB_IDLE;
                gnt_s   = '0;
            end
        endcase
    end

    // State, grant and engine start registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ARB_IDLE;
            gnt_r        <= '0;
            owner_id_r   <= '0;
            last_owner_r <= IW'(R - 1);
            eng_req_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            gnt_r        <= gnt_s;
            owner_id_r   <= owner_id_s;
            last_owner_r <= last_owner_s;
            eng_req_r    <= (state_s == ARB_ISSUE);
        end
    end

    assign gnt          = gnt_r;
    assign owner_id     = owner_id_r;
    assign eng_task_req = eng_req_r;
    assign res_data     = eng_task_res;
    assign res_valid    = res_valid_s;
    assign done         = done_s;

endmodule

// File: tb/tb_iddmm_arb.sv
// Directed self-checking bench for iddmm_arb (R=4, K=16, TIMEOUT=64).
// The watchdog section runs only when IDDMM_ARB_TIMEOUT_EN is defined.
module tb_iddmm_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic [15:0] res_data;
    logic [3:0]  res_valid;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        eng_task_req;
    logic        eng_task_grant;
    logic        eng_task_end;
    logic [15:0] eng_task_res;

    int n_cmp = 0;
    int n_bad = 0;

    iddmm_arb #(.K(16), .N(16), .R(4), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .gnt            (gnt),
        .owner_id       (owner_id),
        .res_data       (res_data),
        .res_valid      (res_valid),
        .done           (done),
        .err            (err),
        .eng_task_req   (eng_task_req),
        .eng_task_grant (eng_task_grant),
        .eng_task_end   (eng_task_end),
        .eng_task_res   (eng_task_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, 4'b0000);
        check({tag, "_owner"}, owner_id, 2'd0);
        check({tag, "_valid"}, res_valid, 4'b0000);
        check({tag, "_done"}, done, 4'b0000);
        check({tag, "_err"}, err, 4'b0000);
        check({tag, "_ereq"}, eng_task_req, 1'b0);
    endtask

    // Waits for the engine start, then plays nwords result words.
    // exp_lat counts cycles from the previous eng_task_end (-1 = unchecked).
    task automatic run_job(input logic [3:0] exp_gnt, input int nwords,
                           input int drop_at, input int exp_lat);
        int n;
        int vcnt;
        n = 1;
        while (eng_task_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("issue_seen", eng_task_req, 1'b1);
        if (exp_lat >= 0) check("req_spacing", n, exp_lat);
        check("gnt", gnt, exp_gnt);
        check("owner_id", owner_id, idx_of(exp_gnt));
        tick();
        check("issue_1cyc", eng_task_req, 1'b0);
        check("owner_stable", owner_id, idx_of(exp_gnt));
        vcnt = 0;
        for (int w = 1; w <= nwords; w++) begin
            eng_task_grant = 1'b1;
            eng_task_end   = (w == nwords);
            eng_task_res   = 16'(w * 3 + 1);
            #1;
            if (res_valid === exp_gnt) vcnt++;
            check("res_data", res_data, 16'(w * 3 + 1));
            check("done", done, (w == nwords) ? exp_gnt : 4'b0000);
            check("err", err, 4'b0000);
            tick();
            if (w == drop_at) req = req & ~exp_gnt;
        end
        eng_task_grant = 1'b0;
        eng_task_end   = 1'b0;
        check("valid_cycles", vcnt, nwords);
        check("gnt_clear", gnt, 4'b0000);
        check("gap_noreq", eng_task_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst_n          = 1'b0;
        req            = 4'b0000;
        eng_task_grant = 1'b0;
        eng_task_end   = 1'b0;
        eng_task_res   = 16'h0000;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single requester, 16 words
        req = 4'b0001;
        run_job(4'b0001, 16, 0, -1);
        req = 4'b0000;
        tick();
        check("idle_gnt", gnt, 4'b0000);

        // Fresh reset so requester 0 leads the contention round
        rst_n = 1'b0;
        #1;
        check_all_zero("rst2");
        tick();
        rst_n = 1'b1;
        tick();

        req = 4'b1111;
        run_job(4'b0001, 4, 0, -1);
        run_job(4'b0010, 4, 0, 3);
        run_job(4'b0100, 4, 0, 3);
        run_job(4'b1000, 4, 0, 3);
        run_job(4'b0001, 4, 0, 3);

        // Owner 2 drops req after word 5, job still completes
        req = 4'b0100;
        run_job(4'b0100, 16, 5, 3);
        check("drop_req_low", req, 4'b0000);

        // Reset at word 8 of requester 3's job
        req = 4'b1000;
        n = 0;
        while (eng_task_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rstjob_gnt", gnt, 4'b1000);
        tick();
        for (int w = 1; w <= 7; w++) begin
            eng_task_grant = 1'b1;
            eng_task_res   = 16'(w);
            tick();
        end
        eng_task_res = 16'd8;
        #1;
        check("rstjob_w8_valid", res_valid, 4'b1000);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        check_all_zero("midrst_next");
        eng_task_grant = 1'b0;
        req            = 4'b0110;
        rst_n          = 1'b1;
        run_job(4'b0010, 4, 0, -1);
        req = 4'b0000;
        tick();

        // Spurious engine strobes while idle
        eng_task_grant = 1'b1;
        eng_task_end   = 1'b1;
        eng_task_res   = 16'hBEEF;
        #1;
        check("spur_valid", res_valid, 4'b0000);
        check("spur_done", done, 4'b0000);
        tick();
        check("spur_gnt", gnt, 4'b0000);
        check("spur_ereq", eng_task_req, 1'b0);
        eng_task_grant = 1'b0;
        eng_task_end   = 1'b0;
        tick();

`ifdef IDDMM_ARB_TIMEOUT_EN
        // Engine never ends: abort at busy cycle 64
        req = 4'b0001;
        n = 0;
        while (eng_task_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("to_gnt", gnt, 4'b0001);
        tick();
        for (int c = 1; c <= 64; c++) begin
            #1;
            check("to_err", err, (c == 64) ? 4'b0001 : 4'b0000);
            check("to_done", done, 4'b0000);
            tick();
        end
        check("to_gnt_clear", gnt, 4'b0000);
        check("to_err_pulse", err, 4'b0000);
        req = 4'b0100;
        run_job(4'b0100, 3, 0, 3);
        req = 4'b0000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
